// File: rtl/afifo_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : afifo_mon_pkg
// Description : Shared types and constants for the multi-channel FIFO flag
//               monitor: error codes, monitor FSM states and code count.
// Revision    : 1.0 - initial release
// ============================================================================
package afifo_mon_pkg;

    localparam int NUM_ERR_CODES = 5;

    // Error codes double as bit positions inside each channel's error vector.
    typedef enum logic [2:0] {
        OVERFLOW       = 3'd0,
        UNDERFLOW      = 3'd1,
        FULL_MISMATCH  = 3'd2,
        EMPTY_MISMATCH = 3'd3,
        DATA_MISMATCH  = 3'd4
    } err_code_e;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        ARMED    = 2'd1,
        CAPTURED = 2'd2
    } mon_state_e;

endpackage : afifo_mon_pkg
`default_nettype wire

// File: rtl/afifo_mon_chan.sv
`default_nettype none
// ============================================================================
// Module      : afifo_mon_chan
// Description : Per-channel slice of the FIFO monitor. Tracks a shadow
//               occupancy from accepted handshakes and produces the raw
//               (unmasked) per-cycle error vector against the pre-update
//               occupancy.
//               Optional macro AFIFO_MON_DATA_CHK_EN adds XOR accumulators
//               over written/read data, compared when the FIFO drains.
// Ports       : clk, rst         - clock / async active-high reset
//               i_winc, i_rinc   - write / read requests
//               i_wfull, i_rempty- flags reported by the monitored FIFO
//               i_wdata, i_rdata - data buses (used only with data check)
//               o_occ            - shadow occupancy (0..DEPTH)
//               o_err            - combinational error vector, bit = code
// Revision    : 1.0 - initial release
// ============================================================================
module afifo_mon_chan
    import afifo_mon_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 8,
    parameter int OCC_W      = $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_winc,
    input  logic                     i_rinc,
    input  logic                     i_wfull,
    input  logic                     i_rempty,
    input  logic [DATA_WIDTH-1:0]    i_wdata,
    input  logic [DATA_WIDTH-1:0]    i_rdata,
    output logic [OCC_W-1:0]         o_occ,
    output logic [NUM_ERR_CODES-1:0] o_err
);

    localparam logic [OCC_W-1:0] c_occ_full = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0] c_occ_one  = OCC_W'(1);

    logic [OCC_W-1:0] r_occ;
    logic             w_wacc;
    logic             w_racc;
    logic             w_is_full;
    logic             w_is_empty;
    logic             w_data_err;

    assign w_wacc     = i_winc && !i_wfull;
    assign w_racc     = i_rinc && !i_rempty;
    assign w_is_full  = (r_occ == c_occ_full);
    assign w_is_empty = (r_occ == '0);

    // Simultaneous accepted write and read leave the count alone. A lone
    // accept that would push the shadow out of range is dropped; the flag
    // mismatch checks already flag the disagreeing FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ <= '0;
        end else if (w_wacc && !w_racc) begin
            if (!w_is_full) begin
                r_occ <= r_occ + 1'b1;
            end
        end else if (w_racc && !w_wacc) begin
            if (!w_is_empty) begin
                r_occ <= r_occ - 1'b1;
            end
        end
    end

    assign o_occ = r_occ;

`ifdef AFIFO_MON_DATA_CHK_EN
    logic [DATA_WIDTH-1:0] r_acc_w;
    logic [DATA_WIDTH-1:0] r_acc_r;
    logic [DATA_WIDTH-1:0] w_acc_w_nxt;
    logic [DATA_WIDTH-1:0] w_acc_r_nxt;
    logic                  w_drain;

    assign w_acc_w_nxt = w_wacc ? (r_acc_w ^ i_wdata) : r_acc_w;
    assign w_acc_r_nxt = w_racc ? (r_acc_r ^ i_rdata) : r_acc_r;

    // The read that takes the shadow from 1 to 0 closes a "frame": every
    // written word has been read, so both folds must agree, including the
    // word being read this cycle.
    assign w_drain    = w_racc && !w_wacc && (r_occ == c_occ_one);
    assign w_data_err = w_drain && (w_acc_w_nxt != w_acc_r_nxt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc_w <= '0;
            r_acc_r <= '0;
        end else if (w_drain) begin
            r_acc_w <= '0;
            r_acc_r <= '0;
        end else begin
            r_acc_w <= w_acc_w_nxt;
            r_acc_r <= w_acc_r_nxt;
        end
    end
`else
    logic w_unused_data;

    assign w_unused_data = ^{i_wdata, i_rdata};
    assign w_data_err    = 1'b0;
`endif

    always_comb begin
        o_err                 = '0;
        o_err[OVERFLOW]       = i_winc && i_wfull;
        o_err[UNDERFLOW]      = i_rinc && i_rempty;
        o_err[FULL_MISMATCH]  = (i_wfull != w_is_full);
        o_err[EMPTY_MISMATCH] = (i_rempty != w_is_empty);
        o_err[DATA_MISMATCH]  = w_data_err;
    end

endmodule : afifo_mon_chan
`default_nettype wire

// File: rtl/afifo_flag_monitor.sv
`default_nettype none
// ============================================================================
// Module      : afifo_flag_monitor
// Description : Multi-channel synchronous FIFO protocol monitor. Shadows the
//               occupancy of NUM_CH FIFOs and reports overflow, underflow
//               and flag mismatches through sticky bits, a saturating error
//               counter, a first-error capture register and an interrupt.
//               Optional macro AFIFO_MON_DATA_CHK_EN enables the per-channel
//               XOR data check (error code 4).
// Ports       : clk, rst          - clock / async active-high reset
//               en                - check enable (occupancy always tracks)
//               clr               - pulse clearing all error state
//               winc, rinc        - per-channel requests
//               wfull, rempty     - per-channel FIFO flags
//               wdata, rdata      - packed data, ch0 in LSBs
//               occ               - packed shadow occupancy
//               err_sticky        - NUM_CH x 5 sticky bits, ch*5+code
//               err_count         - saturating count of error cycles
//               first_err_*       - first-error capture
//               irq               - level interrupt = first_err_valid
// Revision    : 1.0 - initial release
// ============================================================================
module afifo_flag_monitor
    import afifo_mon_pkg::*;
#(
    parameter  int NUM_CH     = 4,
    parameter  int DEPTH      = 16,
    parameter  int DATA_WIDTH = 8,
    parameter  int CNT_WIDTH  = 16,
    localparam int OCC_W      = $clog2(DEPTH) + 1,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic                           clr,
    input  logic [NUM_CH-1:0]              winc,
    input  logic [NUM_CH-1:0]              rinc,
    input  logic [NUM_CH-1:0]              wfull,
    input  logic [NUM_CH-1:0]              rempty,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   wdata,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   rdata,
    output logic [NUM_CH*OCC_W-1:0]        occ,
    output logic [NUM_CH*NUM_ERR_CODES-1:0] err_sticky,
    output logic [CNT_WIDTH-1:0]           err_count,
    output logic                           first_err_valid,
    output logic [CH_W-1:0]                first_err_ch,
    output logic [2:0]                     first_err_code,
    output logic                           irq
);

    localparam int c_err_w = NUM_CH * NUM_ERR_CODES;

    logic [c_err_w-1:0] w_chan_err;
    logic [c_err_w-1:0] w_err;
    logic               w_any_err;
    logic               w_det_en;
    logic               r_rst_dly;
    logic               w_enc_found;
    logic [CH_W-1:0]    w_enc_ch;
    logic [2:0]         w_enc_code;
    mon_state_e         r_state;

    // ------------------------------------------------------------------
    // Channel slices
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
        afifo_mon_chan #(
            .DEPTH      (DEPTH),
            .DATA_WIDTH (DATA_WIDTH),
            .OCC_W      (OCC_W)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .i_winc   (winc[gi]),
            .i_rinc   (rinc[gi]),
            .i_wfull  (wfull[gi]),
            .i_rempty (rempty[gi]),
            .i_wdata  (wdata[gi*DATA_WIDTH +: DATA_WIDTH]),
            .i_rdata  (rdata[gi*DATA_WIDTH +: DATA_WIDTH]),
            .o_occ    (occ[gi*OCC_W +: OCC_W]),
            .o_err    (w_chan_err[gi*NUM_ERR_CODES +: NUM_ERR_CODES])
        );
    end

    // ------------------------------------------------------------------
    // Detection gating. r_rst_dly stays high through reset and for the
    // first edge after release, so flags that settle out of reset are not
    // mistaken for protocol errors.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rst_dly <= 1'b1;
        end else begin
            r_rst_dly <= 1'b0;
        end
    end

    assign w_det_en  = en && !r_rst_dly;
    assign w_err     = w_det_en ? w_chan_err : '0;
    assign w_any_err = |w_err;

    // Lowest channel wins, then lowest code: the flat vector is ordered
    // ch*5+code, so the first set bit from the LSB is the winner.
    always_comb begin
        w_enc_found = 1'b0;
        w_enc_ch    = '0;
        w_enc_code  = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            for (int cd = 0; cd < NUM_ERR_CODES; cd++) begin
                if (!w_enc_found && w_err[ch*NUM_ERR_CODES + cd]) begin
                    w_enc_found = 1'b1;
                    w_enc_ch    = CH_W'(ch);
                    w_enc_code  = 3'(cd);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky bits and saturating counter; clr discards same-cycle errors.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sticky <= '0;
        end else if (clr) begin
            err_sticky <= '0;
        end else begin
            err_sticky <= err_sticky | w_err;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if (clr) begin
            err_count <= '0;
        end else if (w_any_err && (err_count != '1)) begin
            err_count <= err_count + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Capture FSM. Leaving DISABLED goes straight to CAPTURED when a
    // capture is already held, so a retained first error is never
    // overwritten by re-enabling.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= DISABLED;
            first_err_valid <= 1'b0;
            first_err_ch    <= '0;
            first_err_code  <= '0;
        end else if (clr) begin
            r_state         <= en ? ARMED : DISABLED;
            first_err_valid <= 1'b0;
            first_err_ch    <= '0;
            first_err_code  <= '0;
        end else begin
            case (r_state)
                DISABLED: begin
                    if (en) begin
                        r_state <= first_err_valid ? CAPTURED : ARMED;
                    end
                end
                ARMED: begin
                    if (!en) begin
                        r_state <= DISABLED;
                    end else if (w_any_err) begin
                        r_state         <= CAPTURED;
                        first_err_valid <= 1'b1;
                        first_err_ch    <= w_enc_ch;
                        first_err_code  <= w_enc_code;
                    end
                end
                CAPTURED: begin
                    if (!en) begin
                        r_state <= DISABLED;
                    end
                end
                default: begin
                    r_state <= DISABLED;
                end
            endcase
        end
    end

    assign irq = first_err_valid;

endmodule : afifo_flag_monitor
`default_nettype wire

// File: tb/tb_afifo_flag_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_afifo_flag_monitor
// Description : Directed self-checking bench for afifo_flag_monitor with the
//               default configuration (4 channels, depth 16, 8-bit data,
//               16-bit counter). Expected values are hand-computed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_afifo_flag_monitor;

    localparam int NUM_CH     = 4;
    localparam int DEPTH      = 16;
    localparam int DATA_WIDTH = 8;
    localparam int CNT_WIDTH  = 16;
    localparam int OCC_W      = 5;
    localparam int CH_W       = 2;

    logic                         clk;
    logic                         rst;
    logic                         en;
    logic                         clr;
    logic [NUM_CH-1:0]            winc;
    logic [NUM_CH-1:0]            rinc;
    logic [NUM_CH-1:0]            wfull;
    logic [NUM_CH-1:0]            rempty;
    logic [NUM_CH*DATA_WIDTH-1:0] wdata;
    logic [NUM_CH*DATA_WIDTH-1:0] rdata;
    logic [NUM_CH*OCC_W-1:0]      occ;
    logic [NUM_CH*5-1:0]          err_sticky;
    logic [CNT_WIDTH-1:0]         err_count;
    logic                         first_err_valid;
    logic [CH_W-1:0]              first_err_ch;
    logic [2:0]                   first_err_code;
    logic                         irq;

    int n_checks;
    int n_errors;
    int m_occ [NUM_CH];

    afifo_flag_monitor #(
        .NUM_CH     (NUM_CH),
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .en              (en),
        .clr             (clr),
        .winc            (winc),
        .rinc            (rinc),
        .wfull           (wfull),
        .rempty          (rempty),
        .wdata           (wdata),
        .rdata           (rdata),
        .occ             (occ),
        .err_sticky      (err_sticky),
        .err_count       (err_count),
        .first_err_valid (first_err_valid),
        .first_err_ch    (first_err_ch),
        .first_err_code  (first_err_code),
        .irq             (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sampling happens 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive flags consistent with the bench's own occupancy bookkeeping.
    task automatic set_flags();
        for (int c = 0; c < NUM_CH; c++) begin
            wfull[c]  = (m_occ[c] == DEPTH);
            rempty[c] = (m_occ[c] == 0);
        end
    endtask

    function automatic logic [31:0] occ_of(input int c);
        return 32'(occ[c*OCC_W +: OCC_W]);
    endfunction

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int c = 0; c < NUM_CH; c++) m_occ[c] = 0;

        rst    = 1'b1;
        en     = 1'b0;
        clr    = 1'b0;
        winc   = '0;
        rinc   = '0;
        wfull  = '0;
        rempty = '1;
        wdata  = '0;
        rdata  = '0;
        tick();
        tick();

        // ---------------- reset values ----------------
        check("rst_occ",    32'(occ), 32'h0);
        check("rst_sticky", 32'(err_sticky), 32'h0);
        check("rst_count",  32'(err_count), 32'h0);
        check("rst_fev",    32'(first_err_valid), 32'h0);
        check("rst_irq",    32'(irq), 32'h0);

        rst = 1'b0;
        en  = 1'b1;
        tick();

        // ---------------- fill: ch0 x16, ch1 x3, ch2 x16 ----------------
        for (int i = 0; i < 16; i++) begin
            winc = {1'b0, 1'b1, (i < 3), 1'b1};
            set_flags();
            tick();
            m_occ[0]++;
            m_occ[2]++;
            if (i < 3) m_occ[1]++;
            if (i == 7) check("occ0_mid", occ_of(0), 32'd8);
        end
        winc = '0;
        set_flags();
        check("occ0_full", occ_of(0), 32'd16);
        check("occ1_fill", occ_of(1), 32'd3);
        check("occ2_full", occ_of(2), 32'd16);

        // ---------------- drain ch0 ----------------
        for (int i = 0; i < 16; i++) begin
            rinc = 4'b0001;
            set_flags();
            tick();
            m_occ[0]--;
        end
        rinc = '0;
        set_flags();
        check("occ0_empty",   occ_of(0), 32'd0);
        check("clean_count",  32'(err_count), 32'h0);
        check("clean_irq",    32'(irq), 32'h0);
        check("clean_sticky", 32'(err_sticky), 32'h0);

        // ---------------- ch2 overflow ----------------
        winc[2] = 1'b1;
        tick();
        winc = '0;
        check("ovf_sticky", 32'(err_sticky), 32'h400);
        check("ovf_ch",     32'(first_err_ch), 32'd2);
        check("ovf_code",   32'(first_err_code), 32'd0);
        check("ovf_irq",    32'(irq), 32'h1);
        check("ovf_occ2",   occ_of(2), 32'd16);
        check("ovf_count",  32'(err_count), 32'd1);

        // ---------------- clr in the same cycle as a new overflow ----------------
        winc[2] = 1'b1;
        clr     = 1'b1;
        tick();
        winc = '0;
        clr  = 1'b0;
        check("clr_sticky", 32'(err_sticky), 32'h0);
        check("clr_count",  32'(err_count), 32'h0);
        check("clr_fev",    32'(first_err_valid), 32'h0);
        check("clr_ch",     32'(first_err_ch), 32'h0);
        check("clr_irq",    32'(irq), 32'h0);
        check("clr_occ1",   occ_of(1), 32'd3);
        check("clr_occ2",   occ_of(2), 32'd16);

        // ---------------- coincident errors: ch1 code3, ch3 code1 ----------------
        rempty[1] = 1'b1;
        rinc[3]   = 1'b1;
        tick();
        set_flags();
        rinc = '0;
        check("prio_ch",     32'(first_err_ch), 32'd1);
        check("prio_code",   32'(first_err_code), 32'd3);
        check("prio_sticky", 32'(err_sticky), 32'h10100);
        check("prio_count",  32'(err_count), 32'd1);

        // ---------------- en=0 suppresses detection ----------------
        en = 1'b0;
        tick();
        winc[2] = 1'b1;
        tick();
        winc = '0;
        check("dis_count",  32'(err_count), 32'd1);
        check("dis_sticky", 32'(err_sticky), 32'h10100);
        en = 1'b1;
        tick();

        // ---------------- saturation in CAPTURED ----------------
        winc[2] = 1'b1;
        for (int i = 0; i < 100; i++) tick();
        check("sat_partial", 32'(err_count), 32'd101);
        for (int i = 0; i < 65440; i++) tick();
        winc = '0;
        check("sat_count",  32'(err_count), 32'hFFFF);
        check("sat_ch",     32'(first_err_ch), 32'd1);
        check("sat_code",   32'(first_err_code), 32'd3);
        check("sat_sticky", 32'(err_sticky), 32'h10500);

        // ---------------- data check stimulus on ch0 ----------------
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr2_count", 32'(err_count), 32'h0);
        winc[0] = 1'b1;
        wdata[7:0] = 8'hA5;
        set_flags();
        tick();
        m_occ[0]++;
        wdata[7:0] = 8'h3C;
        set_flags();
        tick();
        m_occ[0]++;
        winc = '0;
        wdata = '0;
        rinc[0] = 1'b1;
        rdata[7:0] = 8'hA5;
        set_flags();
        tick();
        m_occ[0]--;
        rdata[7:0] = 8'h00;
        set_flags();
        tick();
        m_occ[0]--;
        rinc = '0;
        set_flags();
        check("dchk_occ0", occ_of(0), 32'd0);
`ifdef AFIFO_MON_DATA_CHK_EN
        check("dchk_sticky", 32'(err_sticky), 32'h10);
        check("dchk_code",   32'(first_err_code), 32'd4);
        check("dchk_ch",     32'(first_err_ch), 32'd0);
        check("dchk_count",  32'(err_count), 32'd1);
`else
        check("dchk_sticky", 32'(err_sticky), 32'h0);
        check("dchk_fev",    32'(first_err_valid), 32'h0);
        check("dchk_count",  32'(err_count), 32'd0);
`endif

        // ---------------- asynchronous reset mid-operation ----------------
        rst = 1'b1;
        #2;
        check("arst_occ",    32'(occ), 32'h0);
        check("arst_sticky", 32'(err_sticky), 32'h0);
        check("arst_irq",    32'(irq), 32'h0);
        for (int c = 0; c < NUM_CH; c++) m_occ[c] = 0;
        // Deliberately wrong empty flags: shadow is 0 on every channel.
        rempty = '0;
        wfull  = '0;
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_supp", 32'(err_sticky), 32'h0);
        tick();
        check("post_rst_sticky", 32'(err_sticky), 32'h42108);
        check("post_rst_ch",     32'(first_err_ch), 32'd0);
        check("post_rst_code",   32'(first_err_code), 32'd3);
        check("post_rst_count",  32'(err_count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_afifo_flag_monitor
`default_nettype wire
